// File: rtl/psc_link_encoder_core.sv
// PSC trigger link front end: clock-enable divider, EVR trigger edge
// detector and CRC-8 byte framer, all on the single system clock.
module psc_link_encoder_core #(
    parameter int          DIV_FAST = 5,
    parameter int          DIV_SLOW = 10,
    parameter logic [7:0]  CRC_POLY = 8'h07,
    parameter logic [7:0]  CRC_INIT = 8'h00
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       evr_trigger,
    input  logic [7:0] data_in,
    input  logic       data_sop,
    input  logic       data_crc,
    output logic       ce_fast,
    output logic       ce_slow,
    output logic       trigger_pulse,
    output logic [9:0] code_out,
    output logic       code_valid
);

    localparam int FW = (DIV_FAST > 1) ? $clog2(DIV_FAST) : 1;
    localparam int SW = (DIV_SLOW > 1) ? $clog2(DIV_SLOW) : 1;
    localparam logic [FW-1:0] FAST_LAST = FW'(DIV_FAST - 1);
    localparam logic [SW-1:0] SLOW_LAST = SW'(DIV_SLOW - 1);

    logic [FW-1:0] fast_cnt;
    logic [SW-1:0] slow_cnt;
    logic          trig_meta;
    logic          trig_sync;
    logic          trig_prev;
    logic [7:0]    crc;
    logic [7:0]    sel_byte;

    // One MSB-first CRC-8 byte update.
    function automatic logic [7:0] crc8_step(
        input logic [7:0] c,
        input logic [7:0] d
    );
        logic [7:0] r;
        r = c ^ d;
        for (int i = 0; i < 8; i++) begin
            if (r[7]) r = {r[6:0], 1'b0} ^ CRC_POLY;
            else      r = {r[6:0], 1'b0};
        end
        return r;
    endfunction

    assign ce_fast = (fast_cnt == FAST_LAST);
    assign ce_slow = ce_fast && (slow_cnt == SLOW_LAST);

    // Fast divider: free-running modulo DIV_FAST.
    always_ff @(posedge clk) begin
        if (reset)        fast_cnt <= '0;
        else if (ce_fast) fast_cnt <= '0;
        else              fast_cnt <= fast_cnt + FW'(1);
    end

    // Slow divider: counts fast ticks modulo DIV_SLOW.
    always_ff @(posedge clk) begin
        if (reset)        slow_cnt <= '0;
        else if (ce_slow) slow_cnt <= '0;
        else if (ce_fast) slow_cnt <= slow_cnt + SW'(1);
    end

    // Two-flop synchronizer for the asynchronous trigger level.
    always_ff @(posedge clk) begin
        if (reset) begin
            trig_meta <= 1'b0;
            trig_sync <= 1'b0;
        end else begin
            trig_meta <= evr_trigger;
            trig_sync <= trig_meta;
        end
    end

    // Rising-edge detect sampled on the slow tick; pulse lasts one slow period.
    always_ff @(posedge clk) begin
        if (reset) begin
            trig_prev     <= 1'b0;
            trigger_pulse <= 1'b0;
        end else if (ce_slow) begin
            trig_prev     <= trig_sync;
            trigger_pulse <= trig_sync & ~trig_prev;
        end
    end

    // The CRC request overrides the data byte, even on an SOP tick.
    always_comb begin
        sel_byte = data_in;
        if (data_crc) sel_byte = crc;
    end

    // Framer: emit {stop, byte, start} and advance the running CRC.
    always_ff @(posedge clk) begin
        if (reset) begin
            crc        <= CRC_INIT;
            code_out   <= 10'h3FF;
            code_valid <= 1'b0;
        end else begin
            code_valid <= ce_slow;
            if (ce_slow) begin
                code_out <= {1'b1, sel_byte, 1'b0};
                if (data_sop || data_crc) crc <= CRC_INIT;
                else                      crc <= crc8_step(crc, data_in);
            end
        end
    end

endmodule

// File: tb/tb_psc_link_encoder_core.sv
// Randomized bench for psc_link_encoder_core with a packet-level
// reference model (CRC by polynomial long division over the packet).
module tb_psc_link_encoder_core;

    typedef struct {
        bit         sop;
        bit         crc;
        logic [7:0] d;
    } cmd_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       evr_trigger;
    logic [7:0] data_in;
    logic       data_sop;
    logic       data_crc;
    logic       ce_fast;
    logic       ce_slow;
    logic       trigger_pulse;
    logic [9:0] code_out;
    logic       code_valid;

    int n_checks = 0;
    int n_pass   = 0;
    int n        = 0;
    int mode     = 0;
    int tp_cnt   = 0;

    bit         th [0:4095];
    cmd_t       cmds[$];
    cmd_t       cur;
    logic [7:0] pkt[$];

    logic       exp_tp, nxt_tp, prev_m;
    logic       exp_cv, nxt_cv;
    logic [9:0] exp_code, nxt_code;

    psc_link_encoder_core dut (
        .clk           (clk),
        .reset         (reset),
        .evr_trigger   (evr_trigger),
        .data_in       (data_in),
        .data_sop      (data_sop),
        .data_crc      (data_crc),
        .ce_fast       (ce_fast),
        .ce_slow       (ce_slow),
        .trigger_pulse (trigger_pulse),
        .code_out      (code_out),
        .code_valid    (code_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got,
                         input logic [15:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s cycle=%0d got=%h exp=%h", tag, n, got, exp);
        else
            n_pass++;
    endtask

    // CRC as remainder of M(x)*x^8 divided by x^8+x^2+x+1.
    function automatic logic [7:0] crc_of();
        logic [8:0] r;
        r = 9'h000;
        foreach (pkt[i]) begin
            for (int b = 7; b >= 0; b--) begin
                r = {r[7:0], pkt[i][b]};
                if (r[8]) r = r ^ 9'h107;
            end
        end
        for (int b = 0; b < 8; b++) begin
            r = {r[7:0], 1'b0};
            if (r[8]) r = r ^ 9'h107;
        end
        return r[7:0];
    endfunction

    function automatic bit th_at(input int i);
        if (i < 1) return 1'b0;
        return th[i];
    endfunction

    function automatic cmd_t rand_cmd();
        cmd_t c;
        int   r;
        r     = $urandom_range(0, 9);
        c.sop = (r < 2) || (r == 4);
        c.crc = (r == 2) || (r == 3) || (r == 4);
        c.d   = 8'($urandom);
        return c;
    endfunction

    task automatic drive(input int k);
        if (k % 50 == 0) begin
            if (cmds.size() > 0) cur = cmds.pop_front();
            else                 cur = rand_cmd();
            data_sop = cur.sop;
            data_crc = cur.crc;
            data_in  = cur.d;
        end else begin
            data_sop = 1'($urandom);
            data_crc = 1'($urandom);
            data_in  = 8'($urandom);
        end
        case (mode)
            1:       evr_trigger = (k >= 60);
            2:       evr_trigger = (k % 50 >= 20) && (k % 50 <= 22);
            3:       if ($urandom_range(0, 79) == 0) evr_trigger = ~evr_trigger;
            default: evr_trigger = 1'b0;
        endcase
        th[k] = evr_trigger;
    endtask

    task automatic model_step();
        logic       s;
        logic [7:0] sel;
        nxt_tp   = exp_tp;
        nxt_cv   = 1'b0;
        nxt_code = exp_code;
        if (n % 50 == 0) begin
            s      = th_at(n - 2);
            nxt_tp = s & ~prev_m;
            prev_m = s;
            sel    = data_crc ? crc_of() : data_in;
            if (data_sop || data_crc) pkt.delete();
            else                      pkt.push_back(data_in);
            nxt_code = {1'b1, sel, 1'b0};
            nxt_cv   = 1'b1;
        end
    endtask

    task automatic run(input int cycles);
        repeat (cycles) begin
            @(negedge clk);
            check("ce_fast", 16'(ce_fast), 16'(n % 5 == 0));
            check("ce_slow", 16'(ce_slow), 16'(n % 50 == 0));
            check("trigger_pulse", 16'(trigger_pulse), 16'(exp_tp));
            check("code_valid", 16'(code_valid), 16'(exp_cv));
            check("code_out", 16'(code_out), 16'(exp_code));
            tp_cnt += int'(trigger_pulse);
            model_step();
            @(posedge clk);
            #1;
            exp_tp   = nxt_tp;
            exp_cv   = nxt_cv;
            exp_code = nxt_code;
            n++;
            drive(n);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset    = 1'b0;
        exp_tp   = 1'b0;
        exp_cv   = 1'b0;
        exp_code = 10'h3FF;
        prev_m   = 1'b0;
        pkt.delete();
        cmds.delete();
        for (int i = 0; i < 4096; i++) th[i] = 1'b0;
        n = 1;
        drive(1);
    endtask

    initial begin
        reset       = 1'b1;
        evr_trigger = 1'b0;
        data_in     = 8'h00;
        data_sop    = 1'b0;
        data_crc    = 1'b0;
        @(posedge clk);
        #1;
        do_reset();

        // Check string packet plus a held trigger raised at cycle 60.
        mode = 1;
        cmds.push_back('{1'b1, 1'b0, 8'h3C});
        for (int i = 0; i < 9; i++)
            cmds.push_back('{1'b0, 1'b0, 8'(8'h31 + i)});
        cmds.push_back('{1'b0, 1'b1, 8'h00});
        tp_cnt = 0;
        run(580);
        check("crc_123456789", 16'(code_out), 16'h03E8);
        check("held_pulse_len", 16'(tp_cnt), 16'd50);

        // SOP, 0x70, CRC -> 0x57.
        mode = 0;
        cmds.push_back('{1'b1, 1'b0, 8'h5A});
        cmds.push_back('{1'b0, 1'b0, 8'h70});
        cmds.push_back('{1'b0, 1'b1, 8'h00});
        run(140);
        check("crc_70", 16'(code_out), 16'h02AE);

        // Short glitches between slow ticks are not detected.
        mode   = 2;
        tp_cnt = 0;
        run(130);
        check("glitch_no_pulse", 16'(tp_cnt), 16'd0);

        // Reset mid-packet discards the running CRC.
        mode = 0;
        cmds.push_back('{1'b1, 1'b0, 8'($urandom)});
        cmds.push_back('{1'b0, 1'b0, 8'($urandom)});
        cmds.push_back('{1'b0, 1'b0, 8'($urandom)});
        run(130);
        do_reset();
        cmds.push_back('{1'b0, 1'b1, 8'($urandom)});
        run(60);
        check("crc_after_reset", 16'(code_out), 16'h0200);

        // Random traffic and trigger activity.
        mode = 3;
        run(2500);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
